// File: rtl/pp_accumulator.sv
// pp_accumulator
//   Collects the four N x M partial products that the multi-cycle DSP
//   multiplier emits for one 2N x 2M multiply. It aligns and extends each
//   partial, adds it into a 2(N+M)-bit accumulator, and hands the finished
//   product to writeback.
//
//   Handshake (both ports): a transfer happens on a rising edge where
//   valid && ready. A producer holds valid and its payload stable until that
//   edge. The result payload (res_data) does not change while
//   res_valid && !res_ready.
//
//   Beat order per product: P0=AL*BL (shift 0), P1=AH*BL (shift N),
//   P2=AL*BH (shift M), P3=AH*BH (shift N+M).
//
//   Optional feature macro: PP_ACC_SINGLE_EN adds pp_single. A first beat
//   with pp_single=1 is taken as a complete native N x M product.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pp_valid/ready  partial-product beat handshake
//   pp_first        beat is P0 of a new product
//   pp_sign         signed product (sampled on the first beat only)
//   pp_data         partial product, N+M bits
//   pp_single       (PP_ACC_SINGLE_EN only) single-beat product
//   res_valid/ready result handshake
//   res_data        assembled product, 2N+2M bits
//   seq_err         registered one-cycle pulse on a sequence violation
module pp_accumulator #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pp_valid,
  output logic                 pp_ready,
  input  logic                 pp_first,
  input  logic                 pp_sign,
  input  logic [N+M-1:0]       pp_data,
`ifdef PP_ACC_SINGLE_EN
  input  logic                 pp_single,
`endif
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*N+2*M-1:0]   res_data,
  output logic                 seq_err
);

  localparam int PW = N + M;
  localparam int AW = 2 * (N + M);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic            err_q, err_d;

  logic            beat;
  logic            single_req;
  logic [AW-1:0]   part_ext;
  logic [AW-1:0]   addend;

  function automatic logic [AW-1:0] ext(input logic [PW-1:0] d, input logic s);
    return s ? {{PW{d[PW-1]}}, d} : {{PW{1'b0}}, d};
  endfunction

`ifdef PP_ACC_SINGLE_EN
  assign single_req = pp_first && pp_single;
`else
  assign single_req = 1'b0;
`endif

  assign pp_ready  = (state_q != S_DONE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = acc_q;
  assign seq_err   = err_q;
  assign beat      = pp_valid && pp_ready;

  // P1..P3 use the sign latched on P0, never the live pp_sign.
  assign part_ext = ext(pp_data, sign_q);

  always_comb begin
    addend = '0;
    case (cnt_q)
      2'd1:    addend = part_ext << N;
      2'd2:    addend = part_ext << M;
      default: addend = part_ext << (N + M);
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (beat) begin
          if (!pp_first) begin
            err_d = 1'b1;
          end else if (single_req) begin
            acc_d   = ext(pp_data, pp_sign);
            sign_d  = pp_sign;
            cnt_d   = 2'd0;
            state_d = S_DONE;
          end else begin
            // P0 is the low-by-low product and is always unsigned.
            acc_d   = ext(pp_data, 1'b0);
            sign_d  = pp_sign;
            cnt_d   = 2'd1;
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (beat) begin
          if (pp_first) begin
            // Restart: drop the partial sum and treat this beat as P0.
            err_d  = 1'b1;
            acc_d  = ext(pp_data, 1'b0);
            sign_d = pp_sign;
            cnt_d  = 2'd1;
          end else begin
            acc_d = acc_q + addend;
            if (cnt_q == 2'd3) begin
              cnt_d   = 2'd0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= 2'd0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pp_accumulator.sv
// tb_pp_accumulator
//   Directed bench for pp_accumulator (N=M=8). Inputs change 1 time unit
//   after a rising edge, and outputs are sampled at that same point.
module tb_pp_accumulator;
  localparam int N  = 8;
  localparam int M  = 8;
  localparam int PW = N + M;
  localparam int AW = 2 * (N + M);

  logic          clk = 1'b0;
  logic          rst;
  logic          pp_valid;
  logic          pp_ready;
  logic          pp_first;
  logic          pp_sign;
  logic [PW-1:0] pp_data;
`ifdef PP_ACC_SINGLE_EN
  logic          pp_single;
`endif
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;
  logic          seq_err;

  int checks   = 0;
  int failures = 0;

  pp_accumulator #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .pp_valid  (pp_valid),
    .pp_ready  (pp_ready),
    .pp_first  (pp_first),
    .pp_sign   (pp_sign),
    .pp_data   (pp_data),
`ifdef PP_ACC_SINGLE_EN
    .pp_single (pp_single),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .seq_err   (seq_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [PW-1:0] d, input logic f, input logic s);
    pp_valid = 1'b1;
    pp_first = f;
    pp_sign  = s;
    pp_data  = d;
    step();
    pp_valid = 1'b0;
    pp_first = 1'b0;
    pp_sign  = 1'b0;
  endtask

  task automatic send_product(input logic [PW-1:0] b0, input logic [PW-1:0] b1,
                              input logic [PW-1:0] b2, input logic [PW-1:0] b3,
                              input logic s, input int gap);
    send_beat(b0, 1'b1, s);
    repeat (gap) step();
    send_beat(b1, 1'b0, 1'b0);
    repeat (gap) step();
    send_beat(b2, 1'b0, 1'b0);
    repeat (gap) step();
    send_beat(b3, 1'b0, 1'b0);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (pp_ready !== 1'b1) begin failures++; $display("FAIL reset_pp_ready got=%b exp=1", pp_ready); end
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++;
    if (res_data !== 32'h0) begin failures++; $display("FAIL reset_res_data got=%h exp=00000000", res_data); end
    checks++;
    if (seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq_err got=%b exp=0", seq_err); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    send_beat(16'h1860, 1'b1, 1'b0);
    send_beat(16'h0870, 1'b0, 1'b0);
    send_beat(16'h1178, 1'b0, 1'b0);
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL unsigned_early_valid got=%b exp=0", res_valid); end
    send_beat(16'h060C, 1'b0, 1'b0);
    checks++;
    if (res_valid !== 1'b1) begin failures++; $display("FAIL unsigned_valid got=%b exp=1", res_valid); end
    checks++;
    if (res_data !== 32'h06260060) begin failures++; $display("FAIL unsigned_data got=%h exp=06260060", res_data); end
    checks++;
    if (pp_ready !== 1'b0) begin failures++; $display("FAIL unsigned_pp_ready got=%b exp=0", pp_ready); end
    checks++;
    if (seq_err !== 1'b0) begin failures++; $display("FAIL unsigned_seq_err got=%b exp=0", seq_err); end
    accept();
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL unsigned_release got=%b exp=0", res_valid); end
  endtask

  task automatic test_signed();
    // Sign is only given on P0; later beats drive pp_sign=0 to show it is latched.
    send_product(16'h01FE, 16'hFFFE, 16'h0000, 16'h0000, 1'b1, 0);
    checks++;
    if (res_data !== 32'hFFFFFFFE) begin failures++; $display("FAIL signed_data got=%h exp=FFFFFFFE", res_data); end
    accept();
    // P2 = -1 at shift 8, P3 = 1 at shift 16.
    send_product(16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 1'b1, 0);
    checks++;
    if (res_data !== 32'h0000FF00) begin failures++; $display("FAIL signed_p2p3 got=%h exp=0000FF00", res_data); end
    accept();
    send_product(16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 1'b0, 0);
    checks++;
    if (res_data !== 32'h0100FF00) begin failures++; $display("FAIL unsigned_p2p3 got=%h exp=0100FF00", res_data); end
    accept();
    // P0 is zero-extended even for a signed product.
    send_product(16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 0);
    checks++;
    if (res_data !== 32'h00008000) begin failures++; $display("FAIL signed_p0_zext got=%h exp=00008000", res_data); end
    accept();
  endtask

  task automatic test_gaps();
    send_product(16'h1860, 16'h0870, 16'h1178, 16'h060C, 1'b0, 3);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h06260060) begin
      failures++; $display("FAIL gaps_result got=%b/%h exp=1/06260060", res_valid, res_data);
    end
    accept();
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] held;
    send_product(16'h1860, 16'h0870, 16'h1178, 16'h060C, 1'b0, 0);
    held = 32'h06260060;
    // Offer a stray beat while the block is full; it must not be taken.
    pp_valid = 1'b1;
    pp_first = 1'b0;
    pp_data  = 16'hABCD;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || pp_ready !== 1'b0 || res_data !== held) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d got=%b/%b/%h exp=1/0/%h", i, res_valid, pp_ready, res_data, held);
      end
      checks++;
      if (seq_err !== 1'b0) begin failures++; $display("FAIL backpressure_seq_err cyc=%0d got=%b exp=0", i, seq_err); end
      step();
    end
    pp_valid = 1'b0;
    accept();
    checks++;
    if (pp_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++; $display("FAIL backpressure_release got=%b/%b exp=1/0", pp_ready, res_valid);
    end
  endtask

  task automatic test_seq_error();
    int pulses = 0;
    // Non-first beat in IDLE is dropped.
    send_beat(16'h1111, 1'b0, 1'b0);
    checks++;
    if (seq_err !== 1'b1) begin failures++; $display("FAIL idle_seq_err got=%b exp=1", seq_err); end
    step();
    checks++;
    if (seq_err !== 1'b0 || pp_ready !== 1'b1) begin
      failures++; $display("FAIL idle_seq_err_clear got=%b/%b exp=0/1", seq_err, pp_ready);
    end
    // Restart on the third beat, then a full sequence.
    send_beat(16'h1860, 1'b1, 1'b0);
    if (seq_err === 1'b1) pulses++;
    send_beat(16'h0870, 1'b0, 1'b0);
    if (seq_err === 1'b1) pulses++;
    send_beat(16'h1860, 1'b1, 1'b0);
    checks++;
    if (seq_err !== 1'b1) begin failures++; $display("FAIL restart_seq_err got=%b exp=1", seq_err); end
    if (seq_err === 1'b1) pulses++;
    send_beat(16'h0870, 1'b0, 1'b0);
    if (seq_err === 1'b1) pulses++;
    send_beat(16'h1178, 1'b0, 1'b0);
    if (seq_err === 1'b1) pulses++;
    send_beat(16'h060C, 1'b0, 1'b0);
    if (seq_err === 1'b1) pulses++;
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL restart_pulse_count got=%0d exp=1", pulses); end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h06260060) begin
      failures++; $display("FAIL restart_result got=%b/%h exp=1/06260060", res_valid, res_data);
    end
    accept();
  endtask

  task automatic test_mid_reset();
    send_beat(16'h1860, 1'b1, 1'b0);
    send_beat(16'h0870, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || pp_ready !== 1'b1 || res_data !== 32'h0) begin
      failures++; $display("FAIL mid_reset got=%b/%b/%h exp=0/1/00000000", res_valid, pp_ready, res_data);
    end
    // Two more non-first beats must not complete the abandoned product.
    send_beat(16'h1178, 1'b0, 1'b0);
    send_beat(16'h060C, 1'b0, 1'b0);
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_no_result got=%b exp=0", res_valid); end
    step();
    send_product(16'h1860, 16'h0870, 16'h1178, 16'h060C, 1'b0, 0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h06260060) begin
      failures++; $display("FAIL mid_reset_recover got=%b/%h exp=1/06260060", res_valid, res_data);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    send_product(16'h01FE, 16'hFFFE, 16'h0000, 16'h0000, 1'b1, 0);
    checks++;
    if (res_data !== 32'hFFFFFFFE) begin failures++; $display("FAIL b2b_first got=%h exp=FFFFFFFE", res_data); end
    accept();
    checks++;
    if (pp_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", pp_ready); end
    send_product(16'h1860, 16'h0870, 16'h1178, 16'h060C, 1'b0, 0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h06260060) begin
      failures++; $display("FAIL b2b_second got=%b/%h exp=1/06260060", res_valid, res_data);
    end
    accept();
  endtask

`ifdef PP_ACC_SINGLE_EN
  task automatic test_single();
    pp_single = 1'b1;
    send_beat(16'h8000, 1'b1, 1'b1);
    pp_single = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'hFFFF8000) begin
      failures++; $display("FAIL single_signed got=%b/%h exp=1/FFFF8000", res_valid, res_data);
    end
    accept();
    pp_single = 1'b1;
    send_beat(16'h8000, 1'b1, 1'b0);
    pp_single = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h00008000) begin
      failures++; $display("FAIL single_unsigned got=%b/%h exp=1/00008000", res_valid, res_data);
    end
    accept();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    pp_valid  = 1'b0;
    pp_first  = 1'b0;
    pp_sign   = 1'b0;
    pp_data   = '0;
    res_ready = 1'b0;
`ifdef PP_ACC_SINGLE_EN
    pp_single = 1'b0;
`endif
    test_reset();
    test_unsigned();
    test_signed();
    test_gaps();
    test_backpressure();
    test_seq_error();
    test_mid_reset();
    test_back_to_back();
`ifdef PP_ACC_SINGLE_EN
    test_single();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
